// File: rtl/card_pkg.sv
// card_pkg: shared definitions for the card dealer.
//   - card encoding {deck[1:0], suit[1:0], rank[3:0]}, rank 1=A..13=K
//   - suit codes, rank bounds, LFSR feedback mask
//   - dealer FSM state type (exported on the dealer's debug port)
package card_pkg;

    localparam int CARD_W = 8;

    localparam logic [1:0] SUIT_COPAS   = 2'b00;
    localparam logic [1:0] SUIT_ESPADAS = 2'b01;
    localparam logic [1:0] SUIT_OUROS   = 2'b10;
    localparam logic [1:0] SUIT_PAUS    = 2'b11;

    localparam logic [3:0] RANK_A = 4'd1;
    localparam logic [3:0] RANK_K = 4'd13;

    // Galois mask for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_PICK,
        ST_SWAP,
        ST_READY,
        ST_EMPTY
    } dealer_state_t;

    function automatic logic [CARD_W-1:0] card_encode(input logic [1:0] deck,
                                                      input logic [1:0] suit,
                                                      input logic [3:0] rank);
        return {deck, suit, rank};
    endfunction

endpackage

// File: rtl/card_dealer_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR (feedback mask LFSR_POLY).
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-low reset, loads seed
//   seed   - reset value; 0 is replaced by 16'h0001 so the register never locks up
//   q      - current LFSR state, advances every cycle
module lfsr16
    import card_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] seed_safe;

    assign seed_safe = (seed == 16'h0000) ? 16'h0001 : seed;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            q <= seed_safe;
        end else if (q[0]) begin
            q <= (q >> 1) ^ LFSR_POLY;
        end else begin
            q <= q >> 1;
        end
    end

endmodule

// File: rtl/card_dealer.sv
// card_dealer: multi-deck shoe with in-place Fisher-Yates shuffle and
// one-card-per-request dealing.
// Build option: AUTO_RESHUFFLE_EN - when defined, dealing the last card
// restarts the shuffle by itself (empty_o pulses for one cycle); when
// undefined the shoe parks in EMPTY until shuffle_i or reset.
// Ports:
//   clk_i          - clock, rising edge
//   rst_i          - asynchronous active-low reset
//   shuffle_i      - pulse: rebuild and reshuffle (beats request_card_i)
//   request_card_i - pulse: deal next card, honoured only while ready_o=1
//   card_o         - last dealt card {deck, suit, rank}
//   card_valid_o   - one-cycle strobe, card_o holds a fresh card
//   ready_o        - shoe shuffled and non-empty
//   empty_o        - every card has been dealt
//   cards_left_o   - undealt card count
//   state_o        - FSM state, for debug observation
// Handshake: a request is accepted on a rising edge where request_card_i=1,
// ready_o=1 and shuffle_i=0; card_valid_o rises exactly one cycle later for
// one cycle. Requests seen while ready_o=0 are dropped, never queued.
module card_dealer
    import card_pkg::*;
#(
    parameter int          NUM_DECKS = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         DECK_SZ   = 52 * NUM_DECKS,
    localparam int         IDX_W     = $clog2(DECK_SZ)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              shuffle_i,
    input  logic              request_card_i,
    output logic [CARD_W-1:0] card_o,
    output logic              card_valid_o,
    output logic              ready_o,
    output logic              empty_o,
    output logic [IDX_W:0]    cards_left_o,
    output dealer_state_t     state_o
);

    dealer_state_t     state, state_nxt;
    logic [CARD_W-1:0] deck [DECK_SZ];
    logic [IDX_W-1:0]  idx_i, idx_j, ptr;
    logic [IDX_W-1:0]  mask_i, j_cand;
    logic [15:0]       lfsr_q;
    logic              lfsr_unused;
    logic              pick_ok, deal_ok, last_card;

    // Smallest 2^n-1 covering v: OR v with all of its right shifts.
    function automatic logic [IDX_W-1:0] cover_mask(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] m;
        m = v;
        for (int b = 1; b < IDX_W; b++) m = m | (v >> b);
        return m;
    endfunction

    lfsr16 u_lfsr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[15:IDX_W];

    // Rejection sampling: a masked draw above i is discarded and retried.
    assign mask_i    = cover_mask(idx_i);
    assign j_cand    = lfsr_q[IDX_W-1:0] & mask_i;
    assign pick_ok   = (j_cand <= idx_i);
    assign deal_ok   = (state == ST_READY) && request_card_i && !shuffle_i;
    assign last_card = (cards_left_o == (IDX_W+1)'(1));

    assign ready_o = (state == ST_READY);
    assign state_o = state;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= ST_INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (shuffle_i) begin
            state_nxt = ST_INIT;
        end else begin
            case (state)
                ST_INIT:  state_nxt = ST_PICK;
                ST_PICK:  if (pick_ok) state_nxt = ST_SWAP;
                ST_SWAP:  state_nxt = (idx_i == IDX_W'(1)) ? ST_READY : ST_PICK;
                ST_READY: begin
                    if (deal_ok && last_card) begin
`ifdef AUTO_RESHUFFLE_EN
                        state_nxt = ST_INIT;
`else
                        state_nxt = ST_EMPTY;
`endif
                    end
                end
                ST_EMPTY: state_nxt = ST_EMPTY;
                default:  state_nxt = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            card_o       <= '0;
            card_valid_o <= 1'b0;
            empty_o      <= 1'b0;
            cards_left_o <= '0;
            ptr          <= '0;
            idx_i        <= '0;
            idx_j        <= '0;
        end else begin
            card_valid_o <= 1'b0;
            if (shuffle_i) begin
                // Reload the count immediately so the reshuffle is visible next cycle.
                empty_o      <= 1'b0;
                cards_left_o <= (IDX_W+1)'(DECK_SZ);
                ptr          <= '0;
            end else begin
                case (state)
                    ST_INIT: begin
                        idx_i        <= IDX_W'(DECK_SZ - 1);
                        ptr          <= '0;
                        cards_left_o <= (IDX_W+1)'(DECK_SZ);
                        // Also ends the single-cycle empty pulse of an automatic reshuffle.
                        empty_o      <= 1'b0;
                    end
                    ST_PICK: begin
                        if (pick_ok) idx_j <= j_cand;
                    end
                    ST_SWAP: begin
                        if (idx_i != IDX_W'(1)) idx_i <= idx_i - 1'b1;
                    end
                    ST_READY: begin
                        if (request_card_i) begin
                            card_o       <= deck[ptr];
                            card_valid_o <= 1'b1;
                            ptr          <= ptr + 1'b1;
                            cards_left_o <= cards_left_o - 1'b1;
                            if (last_card) empty_o <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Shoe storage: rebuilt in order during INIT, permuted in place by SWAP.
    always_ff @(posedge clk_i) begin
        if (state == ST_INIT) begin
            for (int k = 0; k < DECK_SZ; k++) begin
                deck[k] <= card_encode(2'(k / 52), 2'((k % 52) / 13), RANK_A + 4'(k % 13));
            end
        end else if (state == ST_SWAP && !shuffle_i) begin
            deck[idx_i] <= deck[idx_j];
            deck[idx_j] <= deck[idx_i];
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed bench for card_dealer.
// Instance 0: one deck, seed 16'hACE1. Instance 1: two decks, seed 0.
// Honour AUTO_RESHUFFLE_EN the same way the design does.
module tb_card_dealer;
    import card_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic          shuf0, req0, shuf1, req1;
    logic [7:0]    card0, card1;
    logic          val0, val1, rdy0, rdy1, emp0, emp1;
    logic [6:0]    cl0;
    logic [7:0]    cl1;
    dealer_state_t st0, st1;

    card_dealer #(.NUM_DECKS(1), .LFSR_SEED(16'hACE1)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .shuffle_i(shuf0), .request_card_i(req0),
        .card_o(card0), .card_valid_o(val0), .ready_o(rdy0), .empty_o(emp0),
        .cards_left_o(cl0), .state_o(st0)
    );

    card_dealer #(.NUM_DECKS(2), .LFSR_SEED(16'h0000)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .shuffle_i(shuf1), .request_card_i(req1),
        .card_o(card1), .card_valid_o(val1), .ready_o(rdy1), .empty_o(emp1),
        .cards_left_o(cl1), .state_o(st1)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];

    task automatic sb_fill(input int decks);
        exp_q = {};
        for (int d = 0; d < decks; d++)
            for (int s = 0; s < 4; s++)
                for (int r = 1; r <= 13; r++)
                    exp_q.push_back({2'(d), 2'(s), 4'(r)});
    endtask

    task automatic sb_take(input logic [7:0] c);
        int idx;
        idx = -1;
        foreach (exp_q[k]) if (idx < 0 && exp_q[k] == c) idx = k;
        check("sb_card_expected_once", (idx >= 0), 1);
        if (idx >= 0) exp_q.delete(idx);
    endtask

    function automatic int card_index(input logic [7:0] c);
        return int'(c[7:6]) * 52 + int'(c[5:4]) * 13 + int'(c[3:0]) - 1;
    endfunction

    // Count neighbours still in factory order; a real shuffle leaves very few.
    function automatic int ordered_pairs(input logic [7:0] seq[$]);
        int n;
        n = 0;
        for (int k = 0; k + 1 < seq.size(); k++)
            if (card_index(seq[k+1]) == card_index(seq[k]) + 1) n++;
        return n;
    endfunction

    // ---------------- driver helpers ----------------
    task automatic set_req(input int u, input logic v);
        if (u == 0) req0 = v; else req1 = v;
    endtask

    function automatic logic get_val(input int u);
        return (u == 0) ? val0 : val1;
    endfunction

    function automatic logic get_rdy(input int u);
        return (u == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic [7:0] get_card(input int u);
        return (u == 0) ? card0 : card1;
    endfunction

    function automatic int get_cl(input int u);
        return (u == 0) ? int'(cl0) : int'(cl1);
    endfunction

    // One-cycle request; samples the strobe one cycle later.
    task automatic do_request(input int u, output logic v, output logic [7:0] c);
        @(negedge clk);
        check("strobe_gap", get_val(u), 0);
        set_req(u, 1'b1);
        @(negedge clk);
        set_req(u, 1'b0);
        v = get_val(u);
        c = get_card(u);
    endtask

    task automatic wait_ready(input int u, input int budget);
        int cyc;
        cyc = 0;
        while (!get_rdy(u) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_within_budget", (cyc < budget), 1);
    endtask

    task automatic deal_all(input int u, input int n, output logic [7:0] seq[$]);
        logic       v;
        logic [7:0] c;
        seq = {};
        for (int k = 0; k < n; k++) begin
            do_request(u, v, c);
            check("deal_valid", v, 1);
            check("cards_left_step", get_cl(u), n - 1 - k);
            if (v) sb_take(c);
            seq.push_back(c);
        end
        check("sb_all_dealt", exp_q.size(), 0);
    endtask

    // Reset, probe the shuffle window, then deal the whole single-deck shoe.
    task automatic run_deal0(output logic [7:0] seq[$]);
        int         t0;
        logic       v;
        logic [7:0] c;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t0 = cyc_cnt;
        repeat (3) @(negedge clk);
        do_request(0, v, c);
        check("req_during_shuffle_dropped", v, 0);
        check("not_ready_during_shuffle", rdy0, 0);
        check("cards_left_after_init", cl0, 52);
        wait_ready(0, 5000);
        check("shuffle_len_min", ((cyc_cnt - t0) >= 103), 1);
        sb_fill(1);
        deal_all(0, 52, seq);
        check("empty_after_last", emp0, 1);
        check("not_ready_after_last", rdy0, 0);
        check("cards_left_zero", cl0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] seq1[$];
        logic [7:0] seq2[$];
        logic [7:0] seqb[$];
        logic       v;
        logic [7:0] c;
        int         mism;
        int         bad_deck;

        shuf0 = 1'b0; req0 = 1'b0; shuf1 = 1'b0; req1 = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_card", card0, 0);
        check("rst_valid", val0, 0);
        check("rst_ready", rdy0, 0);
        check("rst_empty", emp0, 0);
        check("rst_cards_left", cl0, 0);
        check("rst_cards_left_2deck", cl1, 0);
        check("rst_ready_2deck", rdy1, 0);

        // full deal of one deck
        run_deal0(seq1);
        check("deck1_shuffled", (ordered_pairs(seq1) < 10), 1);

`ifdef AUTO_RESHUFFLE_EN
        @(negedge clk);
        check("auto_empty_pulse_one_cycle", emp0, 0);
        check("auto_not_ready_reshuffling", rdy0, 0);
        check("auto_cards_left_reload", cl0, 52);
        wait_ready(0, 5000);
        check("auto_ready_cards_left", cl0, 52);
        check("auto_empty_low", emp0, 0);
`else
        do_request(0, v, c);
        check("empty_no_strobe", v, 0);
        check("empty_card_hold", c, seq1[51]);
        check("empty_cards_left", cl0, 0);
        check("empty_stays", emp0, 1);
        check("empty_not_ready", rdy0, 0);
`endif

        // identical reset + timing gives the identical sequence
        run_deal0(seq2);
        mism = 0;
        for (int k = 0; k < 52; k++) if (seq1[k] !== seq2[k]) mism++;
        check("repeatable_sequence", mism, 0);

        // shuffle beats a simultaneous request in READY
        @(negedge clk);
        shuf0 = 1'b1;
        @(negedge clk);
        shuf0 = 1'b0;
        check("shuffle_clears_empty", emp0, 0);
        wait_ready(0, 5000);
        do_request(0, v, c);
        check("post_shuffle_deal1", v, 1);
        do_request(0, v, c);
        check("post_shuffle_deal2", v, 1);
        check("post_shuffle_cl", cl0, 50);
        @(negedge clk);
        shuf0 = 1'b1;
        req0  = 1'b1;
        @(negedge clk);
        shuf0 = 1'b0;
        req0  = 1'b0;
        check("shuf_pri_no_strobe", val0, 0);
        check("shuf_pri_not_ready", rdy0, 0);
        check("shuf_pri_cards_left", cl0, 52);
        check("shuf_pri_empty", emp0, 0);
        wait_ready(0, 5000);
        check("shuf_pri_ready_cl", cl0, 52);

        // two decks, seed 0
        wait_ready(1, 5000);
        check("deck2_cards_left_full", cl1, 104);
        sb_fill(2);
        deal_all(1, 104, seqb);
        bad_deck = 0;
        foreach (seqb[k]) if (seqb[k][7:6] > 2'd1) bad_deck++;
        check("deck2_deck_bits", bad_deck, 0);
        check("deck2_shuffled_seed0", (ordered_pairs(seqb) < 10), 1);
        check("deck2_empty", emp1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
Parametrised multi-deck blackjack card dealer, successor to the fixed-sequence card generator. Holds NUM_DECKS x 52 cards in a register array and shuffles them in place with an LFSR-driven Fisher-Yates pass. Deals one card per request through a request/valid handshake. Sits between the game-control FSM and the hand-scoring logic, and reports cards remaining and empty status.

Parameters:
NUM_DECKS, 1, number of 52-card decks in the shoe (1..4; encoded in card bits [7:6]).
LFSR_SEED, 16'hACE1, initial LFSR state; a value of 0 is replaced by 16'h0001.
DECK_SZ, 52*NUM_DECKS, derived localparam: total cards.
IDX_W, $clog2(DECK_SZ), derived localparam: index/pointer width.

Ports:
clk_i  in  1  system clock, rising edge.
rst_i  in  1  asynchronous active-low reset.
shuffle_i  in  1  one-cycle pulse: rebuild and reshuffle the shoe.
request_card_i  in  1  one-cycle pulse: deal next card; honoured only when ready_o=1.
card_o  out  8  dealt card {deck[1:0], suit[1:0], rank[3:0]}; rank 1=A..13=K; suit 00 Copas, 01 Espadas, 10 Ouros, 11 Paus.
card_valid_o  out  1  one-cycle strobe; card_o is valid.
ready_o  out  1  shoe is shuffled, non-empty, and able to accept a request.
empty_o  out  1  all cards have been dealt.
cards_left_o  out  IDX_W+1  undealt card count.

Behaviour:
- Reset: card_o=0, card_valid_o=0, ready_o=0, empty_o=0, cards_left_o=0, lfsr=LFSR_SEED (0 becomes 1), state=INIT.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). Advances every cycle in every state; it is free-running.
- FSM states: INIT, PICK, SWAP, READY, EMPTY.
  - INIT (1 cycle): deck[k] = encoding of card k (k = d*52 + s*13 + r-1). i=DECK_SZ-1, ptr=0, cards_left_o=DECK_SZ. Next state: PICK.
  - PICK: j = lfsr & mask_i, where mask_i is the smallest 2^n-1 >= i. If j<=i, go to SWAP. Otherwise stay in PICK (rejection sampling; no modulo).
  - SWAP: exchange deck[i] and deck[j]. If i==1, go to READY; else i-=1 and go to PICK.
  - READY: ready_o=1. On request_card_i: card_o<=deck[ptr], card_valid_o=1 on the next cycle (latency 1), ptr+=1, cards_left_o-=1. When the last card is dealt, go to EMPTY.
  - EMPTY: empty_o=1, ready_o=0. Requests are ignored (no strobe).
- ready_o is 0 throughout INIT/PICK/SWAP. Requests in those states are dropped, not queued.
- shuffle_i in any state: go to INIT next cycle and clear empty_o. It has priority over a simultaneous request_card_i, and no card is dealt.
- Asynchronous reset mid-shuffle or mid-deal returns to the reset state. The shuffle restarts automatically from INIT.
- card_valid_o is never high for two consecutive cycles unless two consecutive requests are accepted.
- A shuffle of N cards takes at least 2*(N-1)+1 cycles. Expected length is under 4*(N-1).

Optional Feature:
AUTO_RESHUFFLE_EN:
- Defined: dealing the last card causes a transition READY->INIT instead of READY->EMPTY. empty_o pulses high for exactly one cycle, then the shoe reshuffles without needing shuffle_i.
- Undefined: the block stays in EMPTY until shuffle_i or reset.

Decomposition:
- Package card_pkg: suit localparams (SUIT_COPAS..SUIT_PAUS), RANK_A=1 and RANK_K=13, CARD_W=8, LFSR_POLY=16'hB400, and function card_encode(deck, suit, rank).
- Sub-module lfsr16 (clk_i, rst_i, seed, q): free-running Galois LFSR, instantiated once.

Test Plan:
1. NUM_DECKS=1: reset, wait for ready_o, issue 52 requests -> 52 valid strobes. Each of 8'h01..8'h0D, 8'h11..8'h1D, 8'h21..8'h2D, 8'h31..8'h3D appears exactly once. cards_left_o steps 52->0 and empty_o=1.
2. 53rd request while empty_o=1 -> no card_valid_o, card_o holds its last value, cards_left_o stays 0.
3. Two resets with LFSR_SEED=16'hACE1 and identical stimulus timing -> identical 52-card sequences. LFSR_SEED=0 -> behaves as seed 16'h0001, with no lock-up.
4. Request during shuffle (ready_o=0) -> ignored. Simultaneous shuffle_i + request_card_i in READY -> no strobe, ready_o=0 next cycle, cards_left_o reloads to DECK_SZ.
5. NUM_DECKS=2: deal all 104 cards -> every {deck, suit, rank} is unique, and bits [7:6] are only 00 or 01.
6. With AUTO_RESHUFFLE_EN: dealing card 52 -> a one-cycle empty_o pulse, then ready_o returns with cards_left_o=52 and no shuffle_i asserted.
